// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer slice.
// Holds the sequencer state encoding and a width helper.
// Imported by the sequencer top; no logic lives here.
`ifndef RESET_SEQUENCER_PKG_SV
`define RESET_SEQUENCER_PKG_SV

// Index width for an n-entry vector, never narrower than one bit.
`define RS_IDX_WIDTH(n) (((n) > 1) ? $clog2(n) : 1)

package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    GAP        = 2'd0,
    WAIT_READY = 2'd1,
    DONE       = 2'd2,
    ERROR      = 2'd3
  } seq_state_t;

endpackage

`endif

// File: rtl/reset_sequencer_if.sv
// Status/control bundle between the reset sequencer and the domains it releases.
// master: the sequencer (drives stage resets and status).
// slave: the surrounding logic (drives restart request and per-stage ready).
interface reset_sequencer_if #(
  parameter int NumStages = 4,
  parameter int IdxWidth  = 2
);
  logic                 soft_reset_req;
  logic [NumStages-1:0] stage_ready;
  logic [NumStages-1:0] stage_rst;
  logic                 seq_done;
  logic                 seq_error;
  logic [IdxWidth-1:0]  error_stage;

  modport master (
    input  soft_reset_req,
    input  stage_ready,
    output stage_rst,
    output seq_done,
    output seq_error,
    output error_stage
  );

  modport slave (
    output soft_reset_req,
    output stage_ready,
    input  stage_rst,
    input  seq_done,
    input  seq_error,
    input  error_stage
  );
endinterface

// File: rtl/reset_sequencer_terminal_counter.sv
// Up-counter with synchronous clear and enable; flags when the count equals MaxValue.
// The flag is combinational from the registered count (no extra latency).
// The count parks at MaxValue instead of wrapping; clear has priority over enable.
module terminal_counter #(
  parameter int MaxValue = 1,
  parameter int Width    = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [Width-1:0] count;

  assign terminal = (count == Width'(MaxValue));

  // Count up while enabled, hold at the terminal value, restart on clear.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + Width'(1);
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Releases NumStages reset domains in order: gap, release, wait for ready, next stage.
// All outputs registered; a decision made in cycle n is visible in cycle n+1.
// A stage that never reports ready times out, reasserting every stage reset.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NumStages     = 4,
  parameter int StageGap      = 1000,
  parameter int TimeoutCycles = 1000000,
  parameter int GapWidth      = $clog2(StageGap + 1),
  parameter int TimeoutWidth  = $clog2(TimeoutCycles + 1),
  parameter int IdxWidth      = `RS_IDX_WIDTH(NumStages)
) (
  input logic             clk,
  input logic             reset,
  reset_sequencer_if.master bus
);

  seq_state_t           state;
  seq_state_t           state_nxt;
  logic [IdxWidth-1:0]  idx;
  logic [IdxWidth-1:0]  idx_nxt;
  logic [NumStages-1:0] stage_rst_q;
  logic [NumStages-1:0] stage_rst_nxt;
  logic                 seq_done_q;
  logic                 seq_done_nxt;
  logic                 seq_error_q;
  logic                 seq_error_nxt;
  logic [IdxWidth-1:0]  error_stage_q;
  logic [IdxWidth-1:0]  error_stage_nxt;

  logic gap_term;
  logic to_term;
  logic cur_ready;
  logic last_stage;

  // Only the stage currently being waited on is observed.
  assign cur_ready  = bus.stage_ready[idx];
  assign last_stage = (idx == IdxWidth'(NumStages - 1));

  // Gap counter runs only inside GAP and is held at zero everywhere else,
  // so every entry into GAP starts a fresh StageGap-cycle delay.
  terminal_counter #(
    .MaxValue (StageGap - 1),
    .Width    (GapWidth)
  ) u_gap_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (bus.soft_reset_req || (state != GAP)),
    .enable   (state == GAP),
    .terminal (gap_term)
  );

  // Timeout counter likewise only advances while waiting for a ready.
  terminal_counter #(
    .MaxValue (TimeoutCycles - 1),
    .Width    (TimeoutWidth)
  ) u_to_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (bus.soft_reset_req || (state != WAIT_READY)),
    .enable   (state == WAIT_READY),
    .terminal (to_term)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= GAP;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decision; a soft restart overrides whatever the FSM is doing.
  always_comb begin
    state_nxt = state;
    if (bus.soft_reset_req) begin
      state_nxt = GAP;
    end else begin
      case (state)
        GAP: begin
          if (gap_term) state_nxt = WAIT_READY;
        end
        WAIT_READY: begin
          // Ready is checked first so a ready arriving on the timeout cycle wins.
          if (cur_ready)    state_nxt = last_stage ? DONE : GAP;
          else if (to_term) state_nxt = ERROR;
        end
        DONE:    state_nxt = DONE;
        ERROR:   state_nxt = ERROR;
        default: state_nxt = GAP;
      endcase
    end
  end

  // Next values of the stage index and the registered outputs.
  always_comb begin
    idx_nxt         = idx;
    stage_rst_nxt   = stage_rst_q;
    seq_done_nxt    = seq_done_q;
    seq_error_nxt   = seq_error_q;
    error_stage_nxt = error_stage_q;
    if (bus.soft_reset_req) begin
      idx_nxt         = '0;
      stage_rst_nxt   = '1;
      seq_done_nxt    = 1'b0;
      seq_error_nxt   = 1'b0;
      error_stage_nxt = '0;
    end else begin
      case (state)
        GAP: begin
          if (gap_term) stage_rst_nxt[idx] = 1'b0;
        end
        WAIT_READY: begin
          if (cur_ready) begin
            if (last_stage) seq_done_nxt = 1'b1;
            else            idx_nxt      = idx + IdxWidth'(1);
          end else if (to_term) begin
            seq_error_nxt   = 1'b1;
            error_stage_nxt = idx;
            stage_rst_nxt   = '1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output and index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx           <= '0;
      stage_rst_q   <= '1;
      seq_done_q    <= 1'b0;
      seq_error_q   <= 1'b0;
      error_stage_q <= '0;
    end else begin
      idx           <= idx_nxt;
      stage_rst_q   <= stage_rst_nxt;
      seq_done_q    <= seq_done_nxt;
      seq_error_q   <= seq_error_nxt;
      error_stage_q <= error_stage_nxt;
    end
  end

  assign bus.stage_rst   = stage_rst_q;
  assign bus.seq_done    = seq_done_q;
  assign bus.seq_error   = seq_error_q;
  assign bus.error_stage = error_stage_q;

endmodule
